urv_dm_arbiter: RTL and testbench

- Shares the single uRV data-memory port between two requesters: the execute-stage load/store path (core) and a debug/DMA master (dbg).
- Sits between urv_exec's dm_* interface and the memory/bus bridge.
- Grants are registered. Each transaction is held until the memory asserts ready.
- Fixed core priority, with a starvation limit that guarantees dbg progress.

---
 rtl/urv_dm_arbiter.sv | 170 +++++++++++++++++
 tb/tb_urv_dm_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter.sv
// Data-memory port arbiter for uRV: shares one memory port between the execute-stage
// load/store path (core) and a debug/DMA master (dbg), with core priority bounded by a starvation limit.
module urv_dm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_s_i,
    input  logic [3:0]  c_select_i,
    input  logic        c_load_i,
    input  logic        c_store_i,
    output logic        c_ready_o,
    output logic [31:0] c_data_l_o,

    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_s_i,
    input  logic [3:0]  d_select_i,
    input  logic        d_load_i,
    input  logic        d_store_i,
    output logic        d_ready_o,
    output logic [31:0] d_data_l_o,

    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_s_o,
    output logic [3:0]  m_select_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_data_l_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CORE = 2'b01,
        ST_DBG  = 2'b10
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Store has precedence: a simultaneous load strobe is masked. Result is {store, load}.
    function automatic logic [1:0] strobe_sel(input logic load, input logic store);
        strobe_sel = {store, load & ~store};
    endfunction

    function automatic logic [1:0] grant_code(input state_t st);
        case (st)
            ST_CORE: grant_code = 2'b01;
            ST_DBG:  grant_code = 2'b10;
            default: grant_code = 2'b00;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  grant_r;
    logic [3:0]  starve_cnt_r;
    logic        c_req_s;
    logic        d_req_s;
    logic        arb_point_s;
    logic        starve_hit_s;
    logic [1:0]  c_strb_s;
    logic [1:0]  d_strb_s;

    assign c_req_s      = c_load_i | c_store_i;
    assign d_req_s      = d_load_i | d_store_i;
    assign c_strb_s     = strobe_sel(c_load_i, c_store_i);
    assign d_strb_s     = strobe_sel(d_load_i, d_store_i);
    assign starve_hit_s = (starve_cnt_r == STARVE_MAX);

    // Arbitration point: idle, or the owner completes, or the owner withdraws its request.
    always_comb begin
        arb_point_s = 1'b1;
        case (state_r)
            ST_IDLE: arb_point_s = 1'b1;
            ST_CORE: arb_point_s = ~c_req_s | m_ready_i;
            ST_DBG:  arb_point_s = ~d_req_s | m_ready_i;
            default: arb_point_s = 1'b1;
        endcase
    end

    // Next owner; a completing requester that keeps requesting competes as a fresh request.
    always_comb begin
        state_next_s = state_r;
        if (!arb_point_s) begin
            state_next_s = state_r;
        end else if (c_req_s && d_req_s) begin
            state_next_s = starve_hit_s ? ST_DBG : ST_CORE;
        end else if (c_req_s) begin
            state_next_s = ST_CORE;
        end else if (d_req_s) begin
            state_next_s = ST_DBG;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Ownership state and the registered grant code that mirrors it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            grant_r <= 2'b00;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_code(state_next_s);
        end
    end

    // Consecutive core grants made while dbg waits; saturates at the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_r <= 4'd0;
        end else if (!d_req_s) begin
            starve_cnt_r <= 4'd0;
        end else if (arb_point_s && (state_next_s == ST_DBG)) begin
            starve_cnt_r <= 4'd0;
        end else if (arb_point_s && (state_next_s == ST_CORE) && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Memory-side mux; strobes follow the owner's live request so a withdrawal drops them at once.
    always_comb begin
        m_addr_o   = 32'd0;
        m_data_s_o = 32'd0;
        m_select_o = 4'd0;
        m_store_o  = 1'b0;
        m_load_o   = 1'b0;
        c_ready_o  = 1'b0;
        d_ready_o  = 1'b0;
        case (state_r)
            ST_CORE: begin
                m_addr_o   = c_addr_i;
                m_data_s_o = c_data_s_i;
                m_select_o = c_select_i;
                m_store_o  = c_strb_s[1];
                m_load_o   = c_strb_s[0];
                c_ready_o  = m_ready_i & c_req_s;
            end
            ST_DBG: begin
                m_addr_o   = d_addr_i;
                m_data_s_o = d_data_s_i;
                m_select_o = d_select_i;
                m_store_o  = d_strb_s[1];
                m_load_o   = d_strb_s[0];
                d_ready_o  = m_ready_i & d_req_s;
            end
            ST_IDLE: begin
                m_addr_o   = 32'd0;
                m_data_s_o = 32'd0;
                m_select_o = 4'd0;
            end
            default: begin
                m_addr_o   = 32'd0;
                m_data_s_o = 32'd0;
                m_select_o = 4'd0;
            end
        endcase
    end

    assign grant_o    = grant_r;
    assign c_data_l_o = m_data_l_i;
    assign d_data_l_o = m_data_l_i;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Scoreboard bench for urv_dm_arbiter: expected transactions are queued when driven
// and checked against the memory port whenever a ready is issued.
module tb_urv_dm_arbiter;

    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] c_addr_i, c_data_s_i, d_addr_i, d_data_s_i, m_data_l_i;
    logic [3:0]  c_select_i, d_select_i;
    logic        c_load_i, c_store_i, d_load_i, d_store_i, m_ready_i;
    logic        c_ready_o, d_ready_o, m_load_o, m_store_o;
    logic [31:0] c_data_l_o, d_data_l_o, m_addr_o, m_data_s_o;
    logic [3:0]  m_select_o;
    logic [1:0]  grant_o;

    urv_dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_addr_i(c_addr_i), .c_data_s_i(c_data_s_i), .c_select_i(c_select_i),
        .c_load_i(c_load_i), .c_store_i(c_store_i), .c_ready_o(c_ready_o), .c_data_l_o(c_data_l_o),
        .d_addr_i(d_addr_i), .d_data_s_i(d_data_s_i), .d_select_i(d_select_i),
        .d_load_i(d_load_i), .d_store_i(d_store_i), .d_ready_o(d_ready_o), .d_data_l_o(d_data_l_o),
        .m_addr_o(m_addr_o), .m_data_s_o(m_data_s_o), .m_select_o(m_select_o),
        .m_load_o(m_load_o), .m_store_o(m_store_o), .m_ready_i(m_ready_i), .m_data_l_i(m_data_l_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        store;
    } txn_t;

    txn_t c_q[$];
    txn_t d_q[$];
    int   order_q[$];
    int   checks_r   = 0;
    int   failures_r = 0;
    int   c_left     = 0;
    int   d_left     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t cur_c();
        txn_t t;
        t.addr = c_addr_i; t.data = c_data_s_i; t.sel = c_select_i; t.store = c_store_i;
        return t;
    endfunction

    function automatic txn_t cur_d();
        txn_t t;
        t.addr = d_addr_i; t.data = d_data_s_i; t.sel = d_select_i; t.store = d_store_i;
        return t;
    endfunction

    task automatic cmp_txn(input string pfx, input txn_t t, input logic [31:0] ldata);
        check({pfx, "_addr"}, 64'(m_addr_o), 64'(t.addr));
        check({pfx, "_wdata"}, 64'(m_data_s_o), 64'(t.data));
        check({pfx, "_sel"}, 64'(m_select_o), 64'(t.sel));
        check({pfx, "_strobes"}, 64'({m_store_o, m_load_o}), t.store ? 64'd2 : 64'd1);
        check({pfx, "_rdata"}, 64'(ldata), 64'(m_data_l_i));
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on every ready.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("ready_excl", 64'(c_ready_o & d_ready_o), 64'd0);
            check("strobe_owner", 64'((m_load_o | m_store_o) & (grant_o == 2'b00)), 64'd0);
            if (c_ready_o) begin
                order_q.push_back(1);
                check("c_ready_grant", 64'(grant_o), 64'd1);
                if (c_q.size() == 0) check("c_unexpected", 64'(c_q.size()), 64'd1);
                else cmp_txn("c", c_q.pop_front(), c_data_l_o);
            end
            if (d_ready_o) begin
                order_q.push_back(2);
                check("d_ready_grant", 64'(grant_o), 64'd2);
                if (d_q.size() == 0) check("d_unexpected", 64'(d_q.size()), 64'd1);
                else cmp_txn("d", d_q.pop_front(), d_data_l_o);
            end
        end
    end

    task automatic to_sample();
        @(negedge clk_i);
    endtask

    task automatic to_drive();
        @(posedge clk_i);
        #1;
        m_data_l_i = $urandom;
    endtask

    // Reactive requesters: after each ready either issue the next transaction or drop.
    task automatic run_cycles(input int n);
        logic cs, ds;
        for (int i = 0; i < n; i++) begin
            to_sample();
            cs = c_ready_o;
            ds = d_ready_o;
            to_drive();
            if (cs) begin
                if (c_left > 0) begin
                    c_left--;
                    c_addr_i   = c_addr_i + 32'd4;
                    c_data_s_i = c_data_s_i + 32'd1;
                    c_q.push_back(cur_c());
                end else begin
                    c_load_i = 1'b0; c_store_i = 1'b0;
                end
            end
            if (ds) begin
                if (d_left > 0) begin
                    d_left--;
                    d_addr_i = d_addr_i + 32'd4;
                    d_q.push_back(cur_d());
                end else begin
                    d_load_i = 1'b0; d_store_i = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        c_addr_i = 32'd0; c_data_s_i = 32'd0; c_select_i = 4'd0; c_load_i = 1'b0; c_store_i = 1'b0;
        d_addr_i = 32'd0; d_data_s_i = 32'd0; d_select_i = 4'd0; d_load_i = 1'b0; d_store_i = 1'b0;
        m_ready_i = 1'b0; m_data_l_i = 32'd0;

        // Reset state, even with a request and ready present
        to_drive();
        c_load_i = 1'b1; c_addr_i = 32'h55; m_ready_i = 1'b1;
        to_drive();
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_strobes", 64'({m_load_o, m_store_o}), 64'd0);
        check("rst_ready", 64'({c_ready_o, d_ready_o}), 64'd0);
        check("rst_addr", 64'(m_addr_o), 64'd0);
        c_load_i = 1'b0; c_addr_i = 32'd0; m_ready_i = 1'b0;
        to_drive();
        rst_i = 1'b0;
        to_drive();

        // 1: single core load
        c_load_i = 1'b1; c_addr_i = 32'h100; c_select_i = 4'hF;
        c_q.push_back(cur_c());
        to_sample();
        check("t1_c0_grant", 64'(grant_o), 64'd0);
        check("t1_c0_load", 64'(m_load_o), 64'd0);
        to_drive();
        to_sample();
        check("t1_c1_load", 64'(m_load_o), 64'd1);
        check("t1_c1_addr", 64'(m_addr_o), 64'h100);
        check("t1_c1_grant", 64'(grant_o), 64'd1);
        check("t1_c1_ready", 64'(c_ready_o), 64'd0);
        to_drive();
        m_ready_i = 1'b1;
        to_sample();
        check("t1_c2_ready", 64'(c_ready_o), 64'd1);
        to_drive();
        c_load_i = 1'b0; c_addr_i = 32'd0; m_ready_i = 1'b0;
        to_sample();
        check("t1_c3_load", 64'(m_load_o), 64'd0);
        check("t1_c3_ready", 64'(c_ready_o), 64'd0);
        to_drive();
        to_sample();
        check("t1_c4_grant", 64'(grant_o), 64'd0);
        to_drive();

        // 2: simultaneous core store and dbg load
        order_q.delete();
        c_store_i = 1'b1; c_addr_i = 32'h200; c_data_s_i = 32'hDEADBEEF; c_select_i = 4'hF; c_left = 0;
        d_load_i = 1'b1; d_addr_i = 32'h300; d_select_i = 4'hF; d_left = 0;
        m_ready_i = 1'b1;
        c_q.push_back(cur_c());
        d_q.push_back(cur_d());
        run_cycles(6);
        check("t2_count", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            check("t2_first", 64'(order_q[0]), 64'd1);
            check("t2_second", 64'(order_q[1]), 64'd2);
        end

        // 3: starvation limit with continuous core traffic
        order_q.delete();
        c_load_i = 1'b1; c_store_i = 1'b0; c_addr_i = 32'h1000; c_data_s_i = 32'd0; c_left = 7;
        d_load_i = 1'b1; d_addr_i = 32'h400; d_left = 0;
        m_ready_i = 1'b1;
        c_q.push_back(cur_c());
        d_q.push_back(cur_d());
        run_cycles(12);
        check("t3_count", 64'(order_q.size()), 64'd9);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check("t3_order", 64'(order_q[i]), (i == LIMIT) ? 64'd2 : 64'd1);
        m_ready_i = 1'b0;
        to_drive();

        // 4: core withdraws while stalled, dbg takes over
        c_load_i = 1'b1; c_addr_i = 32'h104;
        d_load_i = 1'b1; d_addr_i = 32'h600; d_data_s_i = 32'd0;
        d_q.push_back(cur_d());
        to_sample();
        check("t4_c0_grant", 64'(grant_o), 64'd0);
        to_drive();
        to_sample();
        check("t4_c1_grant", 64'(grant_o), 64'd1);
        check("t4_c1_addr", 64'(m_addr_o), 64'h104);
        to_drive();
        to_drive();
        c_load_i = 1'b0;
        to_sample();
        check("t4_c3_load", 64'(m_load_o), 64'd0);
        check("t4_c3_ready", 64'(c_ready_o), 64'd0);
        to_drive();
        m_ready_i = 1'b1;
        to_sample();
        check("t4_c4_grant", 64'(grant_o), 64'd2);
        check("t4_c4_addr", 64'(m_addr_o), 64'h600);
        to_drive();
        d_load_i = 1'b0; m_ready_i = 1'b0;
        to_sample();
        check("t4_c5_load", 64'(m_load_o), 64'd0);
        to_drive();
        to_sample();
        check("t4_c6_grant", 64'(grant_o), 64'd0);
        to_drive();

        // 5: dbg load+store together -> store only
        d_load_i = 1'b1; d_store_i = 1'b1; d_addr_i = 32'h500; d_data_s_i = 32'hCAFEF00D; d_select_i = 4'h3;
        d_q.push_back(cur_d());
        to_drive();
        to_sample();
        check("t5_store", 64'(m_store_o), 64'd1);
        check("t5_load", 64'(m_load_o), 64'd0);
        check("t5_grant", 64'(grant_o), 64'd2);
        to_drive();
        m_ready_i = 1'b1;
        to_drive();
        d_load_i = 1'b0; d_store_i = 1'b0; m_ready_i = 1'b0;
        to_drive();
        to_sample();
        check("t5_idle", 64'(grant_o), 64'd0);
        to_drive();

        // 6: asynchronous reset mid-DBG, then a pending core request
        d_load_i = 1'b1; d_addr_i = 32'h700; d_select_i = 4'hF;
        to_drive();
        to_sample();
        check("t6_dbg_grant", 64'(grant_o), 64'd2);
        check("t6_dbg_addr", 64'(m_addr_o), 64'h700);
        to_drive();
        c_load_i = 1'b1; c_addr_i = 32'h800; c_data_s_i = 32'd0; c_select_i = 4'hF;
        #2;
        rst_i = 1'b1; m_ready_i = 1'b1;
        #1;
        check("t6_rst_grant", 64'(grant_o), 64'd0);
        check("t6_rst_strobes", 64'({m_load_o, m_store_o}), 64'd0);
        check("t6_rst_ready", 64'({c_ready_o, d_ready_o}), 64'd0);
        check("t6_rst_addr", 64'(m_addr_o), 64'd0);
        to_drive();
        rst_i = 1'b0; m_ready_i = 1'b0; d_load_i = 1'b0;
        c_q.push_back(cur_c());
        to_sample();
        check("t6_rel_grant", 64'(grant_o), 64'd0);
        to_drive();
        m_ready_i = 1'b1;
        to_sample();
        check("t6_core_grant", 64'(grant_o), 64'd1);
        check("t6_core_addr", 64'(m_addr_o), 64'h800);
        to_drive();
        c_load_i = 1'b0; m_ready_i = 1'b0;
        to_drive();
        to_sample();
        check("t6_idle", 64'(grant_o), 64'd0);

        check("c_q_empty", 64'(c_q.size()), 64'd0);
        check("d_q_empty", 64'(d_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
